single_pe_tconv: RTL
====================

SINGLE_PE_TCONV -- requirements
Module: single_pe_tconv

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 start  input  1  request to begin one transposed-convolution run; sampled only in IDLE.
REQ-005 c11, c12, c21, c22  input  8 each  2x2 source map, unsigned; row-major, c<row><col>.
REQ-006 fil11..fil33  input  8 each  3x3 filter, unsigned; row-major, fil<row><col>.
REQ-007 x11..x44  output  8 each  registered 4x4 result map, unsigned; row-major.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  single-cycle pulse; x11..x44 were updated on the same edge.

Function
REQ-010 The block SHALL compute the adjoint of the 3x3 valid convolution: x[p+r][q+s] += c[p][q]*f[r][s], for p,q in 0..1 and r,s in 0..2 (0-indexed).
REQ-011 Filter orientation SHALL be flipped: f[r][s] = fil(3-r)(3-s) in 1-indexed naming, so f[0][0]=fil33 and f[2][2]=fil11.
REQ-012 Arithmetic SHALL be unsigned modulo 2^8: 8-bit product low byte, added to the 8-bit accumulator with carry discarded; no saturation.
REQ-013 The block SHALL use exactly one multiplier, issuing one MAC per cycle, for 36 MAC cycles per run.
REQ-014 MAC order SHALL be k = 9*i + 3*r + s for k = 0..35; source index i = 0,1,2,3 selects c11, c12, c21, c22, so (p,q) = (0,0), (0,1), (1,0), (1,1).
REQ-015 The FSM SHALL have the states IDLE, MAC and DONE.
REQ-016 IDLE -> MAC on an edge with start=1. On that edge the block SHALL capture all c and fil inputs into internal registers, clear all 16 internal accumulators, set count=0 and assert busy.
REQ-017 MAC: each edge SHALL perform step k=count and increment count. After the step with count=35 the FSM SHALL go to DONE.
REQ-018 DONE -> IDLE on the next edge. On that edge x11..x44 SHALL load the accumulators, done SHALL go to 1, and busy SHALL go to 0.
REQ-019 done SHALL be high for exactly one cycle per run.
REQ-020 Timing: with start accepted at edge N, MACs occur at edges N+1..N+36 and done/results appear after edge N+37. The earliest next accept is edge N+38, so the run period is 38 cycles.
REQ-021 start SHALL be ignored in MAC and DONE. Operand input changes after the accept edge SHALL NOT affect the current run.
REQ-022 x11..x44 SHALL hold their values between DONE edges. No partial results are ever visible.
REQ-023 If start stays high continuously, runs SHALL repeat back-to-back, one every 38 cycles.

Reset
REQ-024 While rst=0, regardless of clk: state=IDLE, count=0, busy=0, done=0, x11..x44=0, and all accumulators and captured operands are 0.
REQ-025 Reset asserted mid-run SHALL abort the run without a done pulse. The first start after rst returns to 1 SHALL run normally.

Verification
REQ-026 fil22=1, all other fil=0, c=(1,2,3,4) -> x22=1, x23=2, x32=3, x33=4, all other x=0; done after edge N+37.
REQ-027 All c=1, all fil=1 -> x = outer product of rows/cols [1,2,2,1]: x11=1, x12=2, x22=4, x14=1, x44=1.
REQ-028 Wrap check: c11=16, fil33=17, all else 0 -> x11=16 (272 mod 256); all other x=0.
REQ-029 Reset abort: rst=0 at MAC cycle 20 -> busy=0, done=0, x all 0 immediately. A new start then gives correct results 37 edges later.
REQ-030 start held high for 3 runs with operands changed mid-run -> done pulses spaced 38 cycles apart; each result matches the operands captured at its accept edge.

Source files
------------

// File: rtl/single_pe_tconv_if.sv
// Operand, result and status bundle for the single-PE transposed convolution.
// The master side supplies operands and start; the slave side returns the map.
interface single_pe_tconv_if;
  logic       start;
  logic [7:0] c11, c12, c21, c22;
  logic [7:0] fil11, fil12, fil13, fil21, fil22, fil23, fil31, fil32, fil33;
  logic [7:0] x11, x12, x13, x14, x21, x22, x23, x24;
  logic [7:0] x31, x32, x33, x34, x41, x42, x43, x44;
  logic       busy;
  logic       done;

  modport master (
    output start, c11, c12, c21, c22,
           fil11, fil12, fil13, fil21, fil22, fil23, fil31, fil32, fil33,
    input  x11, x12, x13, x14, x21, x22, x23, x24,
           x31, x32, x33, x34, x41, x42, x43, x44, busy, done
  );

  modport slave (
    input  start, c11, c12, c21, c22,
           fil11, fil12, fil13, fil21, fil22, fil23, fil31, fil32, fil33,
    output x11, x12, x13, x14, x21, x22, x23, x24,
           x31, x32, x33, x34, x41, x42, x43, x44, busy, done
  );
endinterface

// File: rtl/single_pe_tconv.sv
// 2x2 -> 4x4 transposed convolution with a 3x3 filter on one 8-bit multiplier.
// One MAC per cycle, 36 MACs per run, results published only on the DONE edge.
module single_pe_tconv (
  input  logic               clk,
  input  logic               rst,
  single_pe_tconv_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic [1:0] i_q, i_d;
  logic [1:0] r_q, r_d;
  logic [1:0] s_q, s_d;
  logic [7:0] c_q   [4];
  logic [7:0] c_d   [4];
  logic [7:0] f_q   [9];
  logic [7:0] f_d   [9];
  logic [7:0] acc_q [16];
  logic [7:0] acc_d [16];
  logic [7:0] x_q   [16];
  logic [7:0] x_d   [16];
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] c_in_s   [4];
  logic [7:0] fil_in_s [9];
  logic [3:0] rs_s;
  logic [3:0] f_idx_s;
  logic [1:0] row_s;
  logic [1:0] col_s;
  logic [3:0] x_idx_s;
  logic [7:0] c_sel_s;
  logic [7:0] f_sel_s;
  logic [7:0] prod_s;

  assign c_in_s[0]   = bus.c11;
  assign c_in_s[1]   = bus.c12;
  assign c_in_s[2]   = bus.c21;
  assign c_in_s[3]   = bus.c22;
  assign fil_in_s[0] = bus.fil11;
  assign fil_in_s[1] = bus.fil12;
  assign fil_in_s[2] = bus.fil13;
  assign fil_in_s[3] = bus.fil21;
  assign fil_in_s[4] = bus.fil22;
  assign fil_in_s[5] = bus.fil23;
  assign fil_in_s[6] = bus.fil31;
  assign fil_in_s[7] = bus.fil32;
  assign fil_in_s[8] = bus.fil33;

  // Flipped filter: f[r][s] is the captured fil entry at flat index 8-(3r+s).
  assign rs_s    = {1'b0, r_q, 1'b0} + {2'b00, r_q} + {2'b00, s_q};
  assign f_idx_s = 4'd8 - rs_s;
  assign row_s   = {1'b0, i_q[1]} + r_q;
  assign col_s   = {1'b0, i_q[0]} + s_q;
  assign x_idx_s = {row_s, col_s};
  assign c_sel_s = c_q[i_q];
  assign f_sel_s = f_q[f_idx_s];
  assign prod_s  = c_sel_s * f_sel_s;

  assign bus.x11  = x_q[0];
  assign bus.x12  = x_q[1];
  assign bus.x13  = x_q[2];
  assign bus.x14  = x_q[3];
  assign bus.x21  = x_q[4];
  assign bus.x22  = x_q[5];
  assign bus.x23  = x_q[6];
  assign bus.x24  = x_q[7];
  assign bus.x31  = x_q[8];
  assign bus.x32  = x_q[9];
  assign bus.x33  = x_q[10];
  assign bus.x34  = x_q[11];
  assign bus.x41  = x_q[12];
  assign bus.x42  = x_q[13];
  assign bus.x43  = x_q[14];
  assign bus.x44  = x_q[15];
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    i_d     = i_q;
    r_d     = r_q;
    s_d     = s_q;
    c_d     = c_q;
    f_d     = f_q;
    acc_d   = acc_q;
    x_d     = x_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_MAC;
          c_d     = c_in_s;
          f_d     = fil_in_s;
          for (int k = 0; k < 16; k++) begin
            acc_d[k] = 8'd0;
          end
          count_d = 6'd0;
          i_d     = 2'd0;
          r_d     = 2'd0;
          s_d     = 2'd0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MAC: begin
        acc_d[x_idx_s] = acc_q[x_idx_s] + prod_s;
        count_d        = count_q + 6'd1;
        // Walk s fastest, then r, then source index i.
        if (s_q == 2'd2) begin
          s_d = 2'd0;
          if (r_q == 2'd2) begin
            r_d = 2'd0;
            i_d = i_q + 2'd1;
          end else begin
            r_d = r_q + 2'd1;
          end
        end else begin
          s_d = s_q + 2'd1;
        end
        if (count_q == 6'd35) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_MAC;
        end
      end

      ST_DONE: begin
        x_d     = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= 6'd0;
      i_q     <= 2'd0;
      r_q     <= 2'd0;
      s_q     <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        c_q[k] <= 8'd0;
      end
      for (int k = 0; k < 9; k++) begin
        f_q[k] <= 8'd0;
      end
      for (int k = 0; k < 16; k++) begin
        acc_q[k] <= 8'd0;
        x_q[k]   <= 8'd0;
      end
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      i_q     <= i_d;
      r_q     <= r_d;
      s_q     <= s_d;
      c_q     <= c_d;
      f_q     <= f_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
